// File: rtl/fetch_decode.sv
// Fetch/decode front end: 16-entry instruction memory, 4-bit PC, and a
// valid/ready issue port feeding a downstream execute stage.
module fetch_decode #(
    parameter int IMEM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       start,
    input  logic [3:0] run_len,
    input  logic       issue_ready,
    output logic       issue_valid,
    output logic [1:0] op_code,
    output logic [1:0] src_addr1,
    output logic [1:0] src_addr2,
    output logic [1:0] dest_addr,
    output logic [3:0] pc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] ir;
    logic [4:0] remaining;
    logic [7:0] imem [IMEM_DEPTH];

    // Memory has no reset so program contents survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    // pc also serves as the issued count: both start at 0 and step once per handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ir          <= '0;
            remaining   <= '0;
            pc          <= '0;
            issue_valid <= 1'b0;
            op_code     <= '0;
            src_addr1   <= '0;
            src_addr2   <= '0;
            dest_addr   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        pc        <= '0;
                        remaining <= (run_len == 4'd0) ? 5'd16 : {1'b0, run_len};
                    end
                end
                FETCH: begin
                    ir    <= imem[pc];
                    state <= DECODE;
                end
                DECODE: begin
                    op_code     <= ir[7:6];
                    dest_addr   <= ir[5:4];
                    src_addr1   <= ir[3:2];
                    src_addr2   <= ir[1:0];
                    issue_valid <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        remaining   <= remaining - 5'd1;
                        pc          <= pc + 4'd1;
                        if (remaining == 5'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 16, giving the number of 8-bit instruction memory entries. The value is fixed at 16 because the PC is 4 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port prog_we, input, 1 bit: instruction memory write strobe.
REQ-005 The block SHALL have port prog_addr, input, 4 bits: instruction memory write address.
REQ-006 The block SHALL have port prog_data, input, 8 bits: instruction word to write.
REQ-007 The block SHALL have port start, input, 1 bit: begin a run at PC 0.
REQ-008 The block SHALL have port run_len, input, 4 bits: number of instructions in the run; 0 means 16. Sampled on start.
REQ-009 The block SHALL have port issue_ready, input, 1 bit: the downstream execute stage accepts the current instruction.
REQ-010 The block SHALL have port issue_valid, output, 1 bit: decoded fields are valid.
REQ-011 The block SHALL have port op_code, output, 2 bits: 00 add, 01 sub, 10 mul, 11 div.
REQ-012 The block SHALL have ports src_addr1, src_addr2 and dest_addr, outputs, 2 bits each: register file addresses.
REQ-013 The block SHALL have port pc, output, 4 bits: address of the instruction being processed.
REQ-014 The block SHALL have ports busy and done, outputs, 1 bit each. busy is high in every state except IDLE; done is a one-cycle end-of-run pulse.

Function
REQ-015 Instruction format SHALL be: [7:6] op_code, [5:4] dest_addr, [3:2] src_addr1, [1:0] src_addr2.
REQ-016 In IDLE, prog_we=1 SHALL write prog_data to imem[prog_addr] at the clock edge. In all other states, prog_we SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, ISSUE and DONE.
REQ-018 IDLE with start=1 SHALL go to FETCH, set pc=0, set the remaining count to run_len (0 loads 16), and clear the issued count. In any other state, start SHALL be ignored.
REQ-019 FETCH SHALL load the instruction register from imem[pc] and go to DECODE.
REQ-020 DECODE SHALL register op_code, dest_addr, src_addr1 and src_addr2 from the instruction register, assert issue_valid for the next cycle, and go to ISSUE.
REQ-021 In ISSUE, issue_valid SHALL stay high, and all field outputs and pc SHALL stay stable, until issue_ready=1.
REQ-022 A handshake SHALL occur when issue_valid and issue_ready are both 1 at a rising edge. On handshake: drop issue_valid, decrement the remaining count, and increment pc modulo 16.
REQ-023 After a handshake, the FSM SHALL go to DONE if the remaining count was 1, otherwise to FETCH.
REQ-024 Issue rate SHALL be one instruction per 3 cycles at most: handshake to the next issue_valid takes 2 cycles (FETCH, DECODE).
REQ-025 DONE SHALL assert done for exactly one cycle and then return to IDLE. pc SHALL hold its final wrapped value.
REQ-026 With run_len=0 (a 16-instruction run), pc SHALL wrap 15 to 0 on the last handshake.
REQ-027 issue_ready while issue_valid=0 SHALL have no effect.
REQ-028 imem contents SHALL be undefined until written. Reading an unwritten entry is legal and its output is unspecified.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and set pc=0, issue_valid=0, done=0, busy=0, and op_code, src_addr1, src_addr2, dest_addr, the instruction register and both counts to 0.
REQ-030 reset SHALL take priority over start, prog_we and issue_ready in the same cycle.
REQ-031 reset mid-run SHALL abandon the run: no done pulse, with outputs as in REQ-029 on the next cycle.
REQ-032 imem contents SHALL NOT be cleared by reset.

Verification
REQ-033 Load imem[0]=8'b00_11_01_10 and start with run_len=1, with issue_ready held 1. Required: issue_valid is high on cycle 3 after start with op=00, dest=3, src1=1, src2=2, pc=0; done pulses one cycle later; busy then falls.
REQ-034 Hold issue_ready=0 for 5 cycles during ISSUE. Required: issue_valid and all fields stay stable for all 5 cycles; exactly one handshake occurs when issue_ready rises.
REQ-035 run_len=0 with imem[i]=i for all i, issue_ready=1. Required: 16 issues with pc 0..15 and the matching fields; final pc=0; one done pulse.
REQ-036 Assert prog_we and start while busy. Required: imem is unchanged and the current run is unaffected.
REQ-037 Assert reset during ISSUE of a run with run_len=4. Required: next cycle is IDLE with all outputs 0, no done pulse; imem is preserved, so a restarted run issues identical fields.
REQ-038 Assert reset and start in the same cycle. Required: the block stays IDLE with busy=0.
